arcsine_table: RTL and testbench

- Inverse of the angle-to-sine lookup: takes a signed fixed-point sine value and returns the table angle ID whose sine matches it.
- Performs an iterative binary search over the same quarter-wave sine ROM contents (sine_table.mem, 0° to 90°).
- Sits beside the sine lookup in the card-pose path and recovers rotation angles from normalised vector components.
- Valid/ready handshake on both sides, one request in flight.

---
 rtl/arcsine_table.sv | 169 ++++++++++++++++
 tb/tb_arcsine_table.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/arcsine_table.sv
// arcsine_table: signed sine value -> quadrant I/IV angle ID by binary search of the quarter-wave sine ROM.
// Define ASIN_ROUND_EN for round-to-nearest (ties low) instead of floor.
module arcsine_table #(
  parameter int ROM_DEPTH = 64,
  parameter int ROM_WIDTH = 8,
  parameter int ADDRW = $clog2(4*ROM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*ROM_WIDTH-1:0] in_val,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDRW-1:0]       out_angle,
  output logic                   out_sat
);
  localparam int W2 = 2*ROM_WIDTH;
  localparam int LB = $clog2(ROM_DEPTH);
  localparam int BW = $clog2(LB+1);
  localparam logic [W2:0] ONE = {{(W2-ROM_WIDTH){1'b0}}, 1'b1, {ROM_WIDTH{1'b0}}};
  // Contents of sine_table.mem: round(256*sin(k*pi/128)), clamped to the data width
  localparam logic [ROM_WIDTH-1:0] ROM [ROM_DEPTH] = '{
    8'h00, 8'h06, 8'h0D, 8'h13, 8'h19, 8'h1F, 8'h26, 8'h2C,
    8'h32, 8'h38, 8'h3E, 8'h44, 8'h4A, 8'h50, 8'h56, 8'h5C,
    8'h62, 8'h68, 8'h6D, 8'h73, 8'h79, 8'h7E, 8'h84, 8'h89,
    8'h8E, 8'h93, 8'h98, 8'h9D, 8'hA2, 8'hA7, 8'hAC, 8'hB1,
    8'hB5, 8'hB9, 8'hBE, 8'hC2, 8'hC6, 8'hCA, 8'hCE, 8'hD1,
    8'hD5, 8'hD8, 8'hDC, 8'hDF, 8'hE2, 8'hE5, 8'hE7, 8'hEA,
    8'hED, 8'hEF, 8'hF1, 8'hF3, 8'hF5, 8'hF7, 8'hF8, 8'hFA,
    8'hFB, 8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

`ifdef ASIN_ROUND_EN
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CMP, RND_ISSUE, RND_WAIT, RND_CMP, DONE} state_t;
  logic [ROM_WIDTH-1:0] lo_q, lo_d;
  logic [LB-1:0]        k_rnd;
`else
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CMP, DONE} state_t;
`endif

  state_t               state_q, state_d;
  logic [LB-1:0]        k_q, k_d, trial, k_cmp, addr;
  logic [BW-1:0]        b_q, b_d;
  logic                 sign_q, sign_d, hit;
  logic [ROM_WIDTH-1:0] mag_q, mag_d, mem_q, dout_q;
  logic [W2:0]          mag_in;
  logic [ADDRW-1:0]     out_angle_q, out_angle_d;
  logic                 out_sat_q, out_sat_d, out_valid_q, out_valid_d, in_ready_q, in_ready_d;

  function automatic logic [ADDRW-1:0] angle_of(input logic neg, input logic [LB-1:0] k);
    logic [ADDRW-1:0] a;
    a = ADDRW'(k);
    return neg ? -a : a;
  endfunction

  always_comb begin
    mag_in = in_val[W2-1] ? ~{1'b1, in_val} + 1'b1 : {1'b0, in_val};
    trial = k_q | (LB'(1) << b_q);
    hit = dout_q <= mag_q;
    k_cmp = hit ? trial : k_q;
`ifdef ASIN_ROUND_EN
    k_rnd = (dout_q - mag_q) < (mag_q - lo_q) ? k_q + 1'b1 : k_q;
    addr = state_q == RND_ISSUE ? k_q + 1'b1 : trial;
    lo_d = lo_q;
`else
    addr = trial;
`endif
    state_d = state_q;
    k_d = k_q;
    b_d = b_q;
    sign_d = sign_q;
    mag_d = mag_q;
    out_angle_d = out_angle_q;
    out_sat_d = out_sat_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: if (in_valid) begin
        sign_d = in_val[W2-1];
        mag_d = mag_in[ROM_WIDTH-1:0];
        k_d = '0;
        b_d = BW'(LB-1);
`ifdef ASIN_ROUND_EN
        lo_d = '0;
`endif
        state_d = mag_in >= ONE ? DONE : ISSUE;
        out_valid_d = mag_in >= ONE;
        if (mag_in >= ONE) begin
          out_angle_d = in_val[W2-1] ? ADDRW'(3*ROM_DEPTH) : ADDRW'(ROM_DEPTH);
          out_sat_d = mag_in > ONE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: state_d = CMP;
      CMP: begin
        k_d = k_cmp;
        b_d = b_q - 1'b1;
`ifdef ASIN_ROUND_EN
        lo_d = hit ? dout_q : lo_q;
`endif
        if (b_q != '0) state_d = ISSUE;
`ifdef ASIN_ROUND_EN
        else if (k_cmp != LB'(ROM_DEPTH-1)) state_d = RND_ISSUE;
`endif
        else begin
          state_d = DONE;
          out_valid_d = 1'b1;
          out_angle_d = angle_of(sign_q, k_cmp);
          out_sat_d = 1'b0;
        end
      end
`ifdef ASIN_ROUND_EN
      RND_ISSUE: state_d = RND_WAIT;
      RND_WAIT: state_d = RND_CMP;
      RND_CMP: begin
        k_d = k_rnd;
        state_d = DONE;
        out_valid_d = 1'b1;
        out_angle_d = angle_of(sign_q, k_rnd);
        out_sat_d = 1'b0;
      end
`endif
      DONE: if (out_ready) begin
        state_d = IDLE;
        out_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = state_d == IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q <= '0;
      b_q <= '0;
      sign_q <= 1'b0;
      mag_q <= '0;
      mem_q <= '0;
      dout_q <= '0;
      out_angle_q <= '0;
      out_sat_q <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q <= 1'b1;
`ifdef ASIN_ROUND_EN
      lo_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      b_q <= b_d;
      sign_q <= sign_d;
      mag_q <= mag_d;
      mem_q <= ROM[addr];
      dout_q <= mem_q;
      out_angle_q <= out_angle_d;
      out_sat_q <= out_sat_d;
      out_valid_q <= out_valid_d;
      in_ready_q <= in_ready_d;
`ifdef ASIN_ROUND_EN
      lo_q <= lo_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_angle = out_angle_q;
  assign out_sat = out_sat_q;
endmodule

// File: tb/tb_arcsine_table.sv
// tb_arcsine_table: randomized and directed checks of arcsine_table against a sine-table search model.
module tb_arcsine_table;
  logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [15:0] in_val = '0;
  logic       in_ready, out_valid, out_sat;
  logic [7:0] out_angle;
  int checks = 0, passes = 0;
  int tbl [64];

  arcsine_table dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_val(in_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_angle(out_angle), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic void model(input logic [15:0] v, output int ang, output int sat, output int lat);
    int s, mag, k;
    s = int'($signed(v));
    mag = s < 0 ? -s : s;
    k = 0;
    sat = 0;
    if (mag >= 256) begin
      ang = s < 0 ? 192 : 64;
      sat = int'(mag > 256);
      lat = 1;
      return;
    end
    for (int i = 0; i < 64; i++) if (tbl[i] <= mag) k = i;
    lat = 19;
`ifdef ASIN_ROUND_EN
    if (k < 63) begin
      lat = 22;
      if (tbl[k+1] - mag < mag - tbl[k]) k++;
    end
`endif
    ang = s < 0 ? (256 - k) % 256 : k;
  endfunction

  task automatic accept(input logic [15:0] v);
    int n = 0;
    in_val = v;
    in_valid = 1'b1;
    while (!in_ready && n < 60) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("in_ready_timeout", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    if (!out_valid) chk("out_valid_timeout", int'(out_valid), 1);
  endtask

  task automatic txn(input logic [15:0] v, input string tag);
    int lat, ea, es, el;
    model(v, ea, es, el);
    accept(v);
    wait_valid(lat);
    chk($sformatf("%s_%04h_lat", tag, v), lat, el);
    chk($sformatf("%s_%04h_angle", tag, v), int'(out_angle), ea);
    chk($sformatf("%s_%04h_sat", tag, v), int'(out_sat), es);
    @(posedge clk); #1;
    chk($sformatf("%s_%04h_release", tag, v), int'(out_valid), 0);
  endtask

  initial begin
    logic [15:0] dv [7] = '{16'h0100, 16'hFF00, 16'h0180, 16'h8000, 16'h0080, 16'hFF80, 16'h0000};
    int da [7] = '{64, 192, 64, 192, 21, 235, 0};
    int ds [7] = '{0, 0, 1, 1, 0, 0, 0};
    logic [15:0] q [4];
    int got_a[$], got_s[$];
    int ea, es, el, lat, stale;
    logic [15:0] v;
    for (int k = 0; k < 64; k++) begin
      tbl[k] = $rtoi(256.0 * $sin(k * 3.14159265358979 / 128.0) + 0.5);
      if (tbl[k] > 255) tbl[k] = 255;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_angle", int'(out_angle), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    accept(16'h0040);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 0;
    repeat (25) begin @(posedge clk); #1; if (out_valid) stale = 1; end
    chk("midrst_stale", stale, 0);
    txn(16'h0000, "after_rst");

    for (int i = 0; i < 7; i++) begin
      model(dv[i], ea, es, el);
      accept(dv[i]);
      wait_valid(lat);
      chk($sformatf("dir_%04h_lat", dv[i]), lat, el);
      chk($sformatf("dir_%04h_angle", dv[i]), int'(out_angle), da[i]);
      chk($sformatf("dir_%04h_sat", dv[i]), int'(out_sat), ds[i]);
      @(posedge clk); #1;
    end
    chk("fast_lat_const", el, 19 `ifdef ASIN_ROUND_EN + 3 `endif);

    for (int s = -256; s < 256; s++) txn(16'(s), "sweep");
    for (int i = 0; i < 200; i++) begin
      v = i[0] ? 16'($urandom_range(0, 65535)) : 16'(int'($urandom_range(0, 512)) - 256);
      txn(v, "rand");
    end

    out_ready = 1'b0;
    v = 16'(int'($urandom_range(0, 510)) - 255);
    model(v, ea, es, el);
    accept(v);
    wait_valid(lat);
    chk("bp_lat", lat, el);
    for (int i = 0; i < 10; i++) begin
      in_val = 16'($urandom);
      in_valid = i[0];
      @(posedge clk); #1;
      chk($sformatf("bp_angle_%0d", i), int'(out_angle), ea);
      chk($sformatf("bp_sat_%0d", i), int'(out_sat), es);
      chk($sformatf("bp_valid_%0d", i), int'(out_valid), 1);
      chk($sformatf("bp_in_ready_%0d", i), int'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_handshake_valid", int'(out_valid), 0);
    chk("bp_handshake_in_ready", int'(in_ready), 1);
    stale = 0;
    repeat (25) begin @(posedge clk); #1; if (out_valid) stale = 1; end
    chk("bp_ignored_pulses", stale, 0);

    for (int i = 0; i < 4; i++) q[i] = 16'(int'($urandom_range(0, 600)) - 300);
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          int n = 0;
          in_val = q[i];
          in_valid = 1'b1;
          while (!in_ready && n < 60) begin @(posedge clk); #1; n++; end
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        repeat (150) begin
          @(posedge clk); #1;
          if (out_valid) begin got_a.push_back(int'(out_angle)); got_s.push_back(int'(out_sat)); end
        end
      end
    join
    chk("b2b_count", got_a.size(), 4);
    for (int i = 0; i < 4 && i < got_a.size(); i++) begin
      model(q[i], ea, es, el);
      chk($sformatf("b2b_%0d_angle", i), got_a[i], ea);
      chk($sformatf("b2b_%0d_sat", i), got_s[i], es);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
